// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw push-button levels in, conditioned levels and
// pulses out. There is no back-pressure: db is a level, scen/mcen are
// single-cycle strobes that the consumer must accept on the cycle they occur.
interface button_conditioner_if;
    logic [4:0] btn_in;     // raw buttons: 0 up, 1 down, 2 left, 3 right, 4 center
    logic [4:0] db;         // debounced level per button
    logic [4:0] scen;       // one pulse per accepted press
    logic [4:0] mcen;       // press pulse plus auto-repeat pulses while held
    logic       any_db;     // OR of all debounced levels
    logic [9:0] dbg_state;  // per-button FSM state, 2 bits each, button 0 in [1:0]

    modport master (
        output btn_in,
        input  db, scen, mcen, any_db, dbg_state
    );

    modport slave (
        input  btn_in,
        output db, scen, mcen, any_db, dbg_state
    );
endinterface

// File: rtl/button_conditioner.sv
// Five-channel push-button conditioner. Each button gets a 2-flop
// synchronizer, a debounce FSM that accepts a level only after it has been
// stable for 2^DB_BITS clocks, a single-shot press enable (scen) and an
// auto-repeating enable (mcen) with period 2^RPT_BITS while held.
// Every output is a flop; nothing is combinationally derived from btn_in.
module button_conditioner #(
    parameter int DB_BITS  = 20,
    parameter int RPT_BITS = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    localparam int NBTN = 5;

    localparam logic [DB_BITS-1:0]  DB_ONE  = {{(DB_BITS-1){1'b0}}, 1'b1};
    localparam logic [RPT_BITS-1:0] RPT_ONE = {{(RPT_BITS-1){1'b0}}, 1'b1};

    // IDLE: released and quiet.  WQ: rising level seen, waiting for it to
    // stay quiet.  HELD: press accepted.  WR: falling level seen, waiting
    // for it to stay quiet before declaring a release.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WQ   = 2'd1,
        HELD = 2'd2,
        WR   = 2'd3
    } state_t;

    logic [NBTN-1:0]   sync1;
    logic [NBTN-1:0]   sync2;
    logic [NBTN-1:0]   db_nxt;
    logic [NBTN-1:0]   db_r;
    logic [NBTN-1:0]   scen_r;
    logic [NBTN-1:0]   mcen_r;
    logic              any_db_r;
    logic [2*NBTN-1:0] state_dbg;

    // Two-stage synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        state_t              state;
        logic [DB_BITS-1:0]  db_cnt;
        logic [RPT_BITS-1:0] rpt_cnt;
        logic                db_q;
        logic                scen_q;
        logic                mcen_q;
        logic                db_done;
        logic                db_will;

        assign db_done = &db_cnt;

        // Debounced level this button will show after the coming edge;
        // also feeds the registered any_db so it stays aligned with db.
        always_comb begin
            db_will = 1'b0;
            case (state)
                IDLE:    db_will = 1'b0;
                WQ:      db_will = sync2[i] & db_done;
                HELD:    db_will = 1'b1;
                WR:      db_will = sync2[i] | ~db_done;
                default: db_will = 1'b0;
            endcase
        end

        // Debounce / auto-repeat FSM with registered outputs.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state   <= IDLE;
                db_cnt  <= '0;
                rpt_cnt <= '0;
                db_q    <= 1'b0;
                scen_q  <= 1'b0;
                mcen_q  <= 1'b0;
            end else begin
                db_q   <= db_will;
                scen_q <= 1'b0;
                mcen_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (sync2[i]) begin
                            state  <= WQ;
                            db_cnt <= '0;
                        end
                    end
                    WQ: begin
                        if (!sync2[i]) begin
                            // Glitch: abandon the press silently.
                            state  <= IDLE;
                            db_cnt <= '0;
                        end else if (db_done) begin
                            state   <= HELD;
                            rpt_cnt <= '0;
                            scen_q  <= 1'b1;
                            mcen_q  <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                        end
                    end
                    HELD: begin
                        if (!sync2[i]) begin
                            // Repeat phase is frozen while a release is qualified.
                            state  <= WR;
                            db_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_ONE;
                            mcen_q  <= &rpt_cnt;
                        end
                    end
                    WR: begin
                        if (sync2[i]) begin
                            // Bounce during release: resume the hold, no new press.
                            state <= HELD;
                        end else if (db_done) begin
                            state <= IDLE;
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end
                endcase
            end
        end

        assign db_nxt[i]            = db_will;
        assign db_r[i]              = db_q;
        assign scen_r[i]            = scen_q;
        assign mcen_r[i]            = mcen_q;
        assign state_dbg[2*i +: 2]  = state;
    end

    // Registered OR of the debounced levels, updated in step with db.
    always_ff @(posedge clk) begin
        if (!rst) begin
            any_db_r <= 1'b0;
        end else begin
            any_db_r <= |db_nxt;
        end
    end

    assign bus.db        = db_r;
    assign bus.scen      = scen_r;
    assign bus.mcen      = mcen_r;
    assign bus.any_db    = any_db_r;
    assign bus.dbg_state = state_dbg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DB_BITS=3, RPT_BITS=4.
// Reference model: a level is accepted once the synchronized input has
// differed from the current debounced level for 2^DB_BITS+1 consecutive
// samples; repeat pulses come every 2^RPT_BITS held samples, where a sample
// that ends a partial release does not count as a held tick.
module tb_button_conditioner;

    localparam int DBB    = 3;
    localparam int RPB    = 4;
    localparam int NB     = 5;
    localparam int ACCEPT = (1 << DBB) + 1;
    localparam int RPT    = 1 << RPB;

    logic clk = 1'b0;
    logic rst = 1'b0;

    button_conditioner_if bus_if ();

    button_conditioner #(
        .DB_BITS  (DBB),
        .RPT_BITS (RPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Clock
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model, evaluated at each rising edge from pre-edge inputs.
    logic [NB-1:0] m_s1, m_s2, m_db, m_scen, m_mcen;
    int            m_run   [NB];
    int            m_ticks [NB];

    initial begin
        m_s1 = '0; m_s2 = '0; m_db = '0; m_scen = '0; m_mcen = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0;
            m_ticks[i] = 0;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_scen = '0; m_mcen = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = 0;
                m_ticks[i] = 0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                m_scen[i] = 1'b0;
                m_mcen[i] = 1'b0;
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == ACCEPT) begin
                        m_db[i]  = m_s2[i];
                        m_run[i] = 0;
                        if (m_db[i]) begin
                            m_scen[i]  = 1'b1;
                            m_mcen[i]  = 1'b1;
                            m_ticks[i] = 0;
                        end
                    end
                end else begin
                    if (m_db[i] && m_run[i] == 0) begin
                        m_ticks[i]++;
                        if (m_ticks[i] % RPT == 0) m_mcen[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus_if.btn_in;
        end
    end

    // Scoreboard: every cycle, compare DUT against the model.
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("db",     bus_if.db,     m_db);
            check("scen",   bus_if.scen,   m_scen);
            check("mcen",   bus_if.mcen,   m_mcen);
            check("any_db", bus_if.any_db, |m_db);
        end
    end

    logic [NB-1:0] b;
    int            cd [NB];
    logic          seen;
    logic          stay;

    initial begin
        bus_if.btn_in = '0;
        rst = 1'b0;
        step(2);
        chk_en = 1'b1;
        check("rst_db",   bus_if.db,     5'd0);
        check("rst_scen", bus_if.scen,   5'd0);
        check("rst_mcen", bus_if.mcen,   5'd0);
        check("rst_any",  bus_if.any_db, 1'b0);
        rst = 1'b1;
        step(5);

        // Single press with auto-repeat and clean release.
        bus_if.btn_in = 5'b00001;
        step(10); check("p0_db_e10", bus_if.db[0], 1'b0);
        step(1);
        check("p0_db_e11",   bus_if.db[0],   1'b1);
        check("p0_scen_e11", bus_if.scen[0], 1'b1);
        check("p0_mcen_e11", bus_if.mcen[0], 1'b1);
        step(1);
        check("p0_scen_e12", bus_if.scen[0], 1'b0);
        check("p0_mcen_e12", bus_if.mcen[0], 1'b0);
        step(14); check("p0_mcen_e26", bus_if.mcen[0], 1'b0);
        step(1);  check("p0_mcen_e27", bus_if.mcen[0], 1'b1);
        step(15); check("p0_mcen_e42", bus_if.mcen[0], 1'b0);
        step(1);  check("p0_mcen_e43", bus_if.mcen[0], 1'b1);
        bus_if.btn_in = 5'b00000;
        step(10); check("r0_db_e10", bus_if.db[0], 1'b1);
        step(1);  check("r0_db_e11", bus_if.db[0], 1'b0);
        step(5);

        // Short pulse on button 2 is rejected.
        seen = 1'b0;
        bus_if.btn_in = 5'b00100;
        for (int k = 0; k < 25; k++) begin
            if (k == 5) bus_if.btn_in = 5'b00000;
            step(1);
            seen = seen | bus_if.db[2] | bus_if.scen[2] | bus_if.mcen[2];
        end
        check("glitch2", seen, 1'b0);

        // Release bounce: db holds, no second scen; then clean release.
        bus_if.btn_in = 5'b00001;
        step(20);
        bus_if.btn_in = 5'b00000;
        stay = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k == 4) bus_if.btn_in = 5'b00001;
            step(1);
            stay = stay & bus_if.db[0];
            seen = seen | bus_if.scen[0];
        end
        check("bounce_db",   stay, 1'b1);
        check("bounce_scen", seen, 1'b0);
        bus_if.btn_in = 5'b00000;
        step(10); check("bounce_rel_e10", bus_if.db[0], 1'b1);
        step(1);  check("bounce_rel_e11", bus_if.db[0], 1'b0);
        step(5);

        // Simultaneous presses on buttons 1 and 3.
        bus_if.btn_in = 5'b01010;
        step(10); check("sim_db_e10", bus_if.db, 5'b00000);
        step(1);
        check("sim_db_e11",   bus_if.db,     5'b01010);
        check("sim_scen_e11", bus_if.scen,   5'b01010);
        check("sim_any_e11",  bus_if.any_db, 1'b1);
        step(1);  check("sim_scen_e12", bus_if.scen, 5'b00000);
        bus_if.btn_in = 5'b00000;
        step(15);

        // Reset while button 4 is held; held button is re-accepted afterwards.
        bus_if.btn_in = 5'b10000;
        step(14);
        check("hold4_db", bus_if.db[4], 1'b1);
        rst = 1'b0;
        step(1);
        check("mid_rst_db",   bus_if.db,     5'd0);
        check("mid_rst_scen", bus_if.scen,   5'd0);
        check("mid_rst_mcen", bus_if.mcen,   5'd0);
        check("mid_rst_any",  bus_if.any_db, 1'b0);
        rst = 1'b1;
        step(10); check("post_rst_db_e10", bus_if.db[4], 1'b0);
        step(1);
        check("post_rst_db_e11",   bus_if.db[4], 1'b1);
        check("post_rst_scen_e11", bus_if.scen,  5'b10000);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            seen = seen | bus_if.scen[4];
        end
        check("post_rst_one_scen", seen, 1'b0);
        bus_if.btn_in = 5'b00000;
        step(15);

        // Randomized mix of glitches, long holds and occasional resets.
        b = '0;
        for (int i = 0; i < NB; i++) cd[i] = $urandom_range(0, 20);
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (cd[i] == 0) begin
                    b[i] = ~b[i];
                    cd[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8)
                                                        : $urandom_range(10, 45);
                end else begin
                    cd[i]--;
                end
            end
            bus_if.btn_in = b;
            rst = ($urandom_range(0, 299) != 0);
            step(1);
        end
        rst = 1'b1;
        bus_if.btn_in = '0;
        step(20);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
